// File: rtl/sop_pkg.sv
// Shared types and helpers for the sum-of-products engine: FSM states,
// counter sizing and lane slicing of the packed operand buses.
package sop_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPUTE = 2'd1,
      ST_REDUCE  = 2'd2
   } state_t;

   localparam int LAT_MAX = 8;
   localparam int NCH_MAX = 8;

   function automatic int cnt_width(input int lat);
      return $clog2(lat + 1);
   endfunction

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/sop_lane.sv
// One lane: registered operands, then a LAT-stage ce-enabled pipeline of a*b+c wrapped to RES_W.
// Latency LAT enabled edges after load; ce=0 freezes every stage.
module sop_lane
   import sop_pkg::*;
#(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int C_W   = 32,
   parameter int RES_W = 32,
   parameter int LAT   = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    ce,
   input  logic                    i_load,
   input  logic signed [A_W-1:0]   i_a,
   input  logic signed [B_W-1:0]   i_b,
   input  logic signed [C_W-1:0]   i_c,
   output logic [RES_W-1:0]        o_res
);

   localparam int P_W = A_W + B_W;

   logic signed [A_W-1:0]   a_q, a_d;
   logic signed [B_W-1:0]   b_q, b_d;
   logic signed [C_W-1:0]   c_q, c_d;
   logic [RES_W-1:0]        pipe_q [LAT];
   logic [RES_W-1:0]        pipe_d [LAT];
   logic signed [P_W-1:0]   prod;
   logic signed [RES_W-1:0] res;

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      if (i_load) begin
         a_d = i_a;
         b_d = i_b;
         c_d = i_c;
      end
      prod = a_q * b_q;
      // Signed size casts sign-extend or truncate, giving the mod-2^RES_W sum directly.
      res  = RES_W'(prod) + RES_W'(c_q);
      pipe_d[0] = res;
      for (int s = 1; s < LAT; s++) begin
         pipe_d[s] = pipe_q[s-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         for (int s = 0; s < LAT; s++) begin
            pipe_q[s] <= '0;
         end
      end else if (ce) begin
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         for (int s = 0; s < LAT; s++) begin
            pipe_q[s] <= pipe_d[s];
         end
      end
   end

   assign o_res = pipe_q[LAT-1];

endmodule

// File: rtl/sop_reduce_engine.sv
// N-lane a*b+c engine behind a req/busy/done handshake; result LAT+1 enabled edges after accept.
// Requests while busy are dropped; ce=0 stalls all state including the done pulse.
module sop_reduce_engine
   import sop_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int C_W   = 32,
   parameter int RES_W = 32,
   parameter int LAT   = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 ce,
   input  logic                 i_main_req,
   input  logic                 i_acc,
   input  logic [NCH*A_W-1:0]   i_a,
   input  logic [NCH*B_W-1:0]   i_b,
   input  logic [NCH*C_W-1:0]   i_c,
   output logic                 o_main_busy,
   output logic                 o_main_done,
   output logic [RES_W-1:0]     o_main_return
);

   localparam int CNT_W = cnt_width(LAT);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               acc_q, acc_d;
   logic [RES_W-1:0]   ret_q, ret_d;
   logic [RES_W-1:0]   lane_res [NCH];
   logic [RES_W-1:0]   lane_sum;
   logic               load;

   assign load = ce && (state_q == ST_IDLE) && i_main_req;

   for (genvar k = 0; k < NCH; k++) begin : g_lane
      sop_lane #(
         .A_W   (A_W),
         .B_W   (B_W),
         .C_W   (C_W),
         .RES_W (RES_W),
         .LAT   (LAT)
      ) u_lane (
         .clock   (clock),
         .reset_n (reset_n),
         .ce      (ce),
         .i_load  (load),
         .i_a     (i_a[lane_lsb(k, A_W) +: A_W]),
         .i_b     (i_b[lane_lsb(k, B_W) +: B_W]),
         .i_c     (i_c[lane_lsb(k, C_W) +: C_W]),
         .o_res   (lane_res[k])
      );
   end

   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < NCH; k++) begin
         lane_sum = lane_sum + lane_res[k];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      acc_d   = acc_q;
      ret_d   = ret_q;
      case (state_q)
         ST_IDLE: begin
            if (i_main_req) begin
               acc_d   = i_acc;
               busy_d  = 1'b1;
               cnt_d   = CNT_W'(1);
               state_d = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (cnt_q == CNT_W'(LAT)) begin
               state_d = ST_REDUCE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_REDUCE: begin
            ret_d   = (acc_q ? ret_q : '0) + lane_sum;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         acc_q   <= 1'b0;
         ret_q   <= '0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         acc_q   <= acc_d;
         ret_q   <= ret_d;
      end
   end

   assign o_main_busy   = busy_q;
   assign o_main_done   = done_q;
   assign o_main_return = ret_q;

endmodule

// File: tb/tb_sop_reduce_engine.sv
// Bench: a LAT=1 and a LAT=4 engine (NCH=2) sharing operand buses, checked against
// spec-derived constants and an arithmetic reference model.
module tb_sop_reduce_engine;

   localparam int NCH = 2;
   localparam int A_W = 16;
   localparam int B_W = 16;
   localparam int C_W = 32;
   localparam int RES_W = 32;

   logic                 clock = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 ce = 1'b1;
   logic                 i_acc = 1'b0;
   logic                 req1 = 1'b0;
   logic                 req4 = 1'b0;
   logic [NCH*A_W-1:0]   i_a = '0;
   logic [NCH*B_W-1:0]   i_b = '0;
   logic [NCH*C_W-1:0]   i_c = '0;
   logic                 busy1, done1, busy4, done4;
   logic [RES_W-1:0]     ret1, ret4;

   int n_pass = 0;
   int n_total = 0;
   logic [31:0] m_ret [2];

   always #5 clock = ~clock;

   sop_reduce_engine #(.NCH(NCH), .A_W(A_W), .B_W(B_W), .C_W(C_W), .RES_W(RES_W), .LAT(1)) u_lat1 (
      .clock(clock), .reset_n(reset_n), .ce(ce), .i_main_req(req1), .i_acc(i_acc),
      .i_a(i_a), .i_b(i_b), .i_c(i_c),
      .o_main_busy(busy1), .o_main_done(done1), .o_main_return(ret1)
   );

   sop_reduce_engine #(.NCH(NCH), .A_W(A_W), .B_W(B_W), .C_W(C_W), .RES_W(RES_W), .LAT(4)) u_lat4 (
      .clock(clock), .reset_n(reset_n), .ce(ce), .i_main_req(req4), .i_acc(i_acc),
      .i_a(i_a), .i_b(i_b), .i_c(i_c),
      .o_main_busy(busy4), .o_main_done(done4), .o_main_return(ret4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                    name, $signed(act), act, $signed(exp), exp);
   endtask

   // Reference: sum over lanes of a*b+c in wide integer arithmetic, then wrap to 32 bits.
   function automatic logic [31:0] model(input logic [31:0] prev, input logic acc,
                                         input logic [31:0] a_bus, input logic [31:0] b_bus,
                                         input logic [63:0] c_bus);
      longint s;
      s = acc ? longint'($signed(prev)) : 64'sd0;
      for (int k = 0; k < NCH; k++) begin
         s += longint'($signed(a_bus[k*16 +: 16])) * longint'($signed(b_bus[k*16 +: 16]))
              + longint'($signed(c_bus[k*32 +: 32]));
      end
      return s[31:0];
   endfunction

   function automatic logic get_done(input int sel);
      return (sel == 1) ? done1 : done4;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel == 1) ? busy1 : busy4;
   endfunction
   function automatic logic [31:0] get_ret(input int sel);
      return (sel == 1) ? ret1 : ret4;
   endfunction

   task automatic set_req(input int sel, input logic v);
      if (sel == 1) req1 = v;
      else req4 = v;
   endtask

   task automatic run_op(input int sel, input logic [31:0] a_bus, input logic [31:0] b_bus,
                         input logic [63:0] c_bus, input logic acc, input logic [31:0] exp_ret,
                         input int exp_busy, input int stall, input bit poke, input string name);
      int  busy_cnt;
      bit  done_seen;
      busy_cnt  = 0;
      done_seen = 0;
      @(negedge clock);
      i_a = a_bus; i_b = b_bus; i_c = c_bus; i_acc = acc;
      set_req(sel, 1'b1);
      @(negedge clock);
      set_req(sel, 1'b0);
      i_a = $urandom; i_b = $urandom; i_c = {$urandom, $urandom}; i_acc = ~acc;
      for (int t = 0; t < 60; t++) begin
         if (get_done(sel)) begin
            done_seen = 1;
            break;
         end
         if (get_busy(sel)) busy_cnt++;
         if (stall > 0 && t == 1) ce = 1'b0;
         if (stall > 0 && t == 1 + stall) ce = 1'b1;
         if (poke && t == stall + 2) set_req(sel, 1'b1);
         if (poke && t == stall + 3) set_req(sel, 1'b0);
         @(negedge clock);
      end
      ce = 1'b1;
      set_req(sel, 1'b0);
      chk({name, "_done_seen"}, 32'(done_seen), 32'd1);
      chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      chk({name, "_ret"}, get_ret(sel), exp_ret);
      @(negedge clock);
      chk({name, "_done_drop"}, 32'(get_done(sel)), 32'd0);
      chk({name, "_idle_after"}, 32'(get_busy(sel)), 32'd0);
   endtask

   typedef struct {
      int sel;
      int a0, b0, c0, a1, b1, c1;
      bit acc;
      int exp;
      int busy;
      int stall;
      bit poke;
   } vec_t;

   vec_t tbl [6];

   initial begin
      logic [31:0] a_bus, b_bus, exp_v, cur_exp;
      logic [63:0] c_bus;
      logic        acc_v;
      int          st;

      tbl[0] = '{1, 10, 20, 30, 40, 50, 60, 1'b0, 2290, 2, 0, 1'b0};
      tbl[1] = '{1, 10, 20, 30, 40, 50, 60, 1'b1, 4580, 2, 0, 1'b0};
      tbl[2] = '{1, -3, 7, -1, 0, 0, 0, 1'b0, -22, 2, 0, 1'b0};
      tbl[3] = '{1, 32767, 32767, 32'h7FFFFFFF, 0, 0, 0, 1'b0, -1073807360, 2, 0, 1'b0};
      tbl[4] = '{4, 10, 20, 30, 40, 50, 60, 1'b0, 2290, 5, 0, 1'b0};
      tbl[5] = '{4, 10, 20, 30, 40, 50, 60, 1'b0, 2290, 8, 3, 1'b1};
      m_ret[0] = '0;
      m_ret[1] = '0;

      #3;
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_done1", 32'(done1), 32'd0);
      chk("rst_ret1", ret1, 32'd0);
      chk("rst_busy4", 32'(busy4), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
      chk("rst_ret4", ret4, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < 6; i++) begin
         a_bus = {16'(tbl[i].a1), 16'(tbl[i].a0)};
         b_bus = {16'(tbl[i].b1), 16'(tbl[i].b0)};
         c_bus = {32'(tbl[i].c1), 32'(tbl[i].c0)};
         run_op(tbl[i].sel, a_bus, b_bus, c_bus, tbl[i].acc, 32'(tbl[i].exp),
                tbl[i].busy, tbl[i].stall, tbl[i].poke, $sformatf("vec%0d", i));
         m_ret[(tbl[i].sel == 1) ? 0 : 1] = 32'(tbl[i].exp);
      end

      for (int r = 0; r < 6; r++) begin
         a_bus = (r == 0) ? 32'h80008000 : $urandom;
         b_bus = (r == 0) ? 32'h80008000 : $urandom;
         c_bus = {$urandom, $urandom};
         acc_v = 1'($urandom_range(0, 1));
         st    = $urandom_range(0, 2);
         exp_v = model(m_ret[1], acc_v, a_bus, b_bus, c_bus);
         run_op(4, a_bus, b_bus, c_bus, acc_v, exp_v, 5 + st, st, 1'b0, $sformatf("rnd%0d", r));
         m_ret[1] = exp_v;
      end

      @(negedge clock);
      i_a = 32'h00050003; i_b = 32'h00070002; i_c = 64'd9; i_acc = 1'b0;
      req4 = 1'b1;
      @(negedge clock);
      req4 = 1'b0;
      @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_busy4", 32'(busy4), 32'd0);
      chk("arst_done4", 32'(done4), 32'd0);
      chk("arst_ret4", ret4, 32'd0);
      chk("arst_ret1", ret1, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      m_ret[0] = '0;
      m_ret[1] = '0;
      a_bus = 32'hFFF60064; b_bus = 32'h00030005; c_bus = {32'd7, 32'hFFFFFFFE};
      exp_v = model(m_ret[1], 1'b1, a_bus, b_bus, c_bus);
      run_op(4, a_bus, b_bus, c_bus, 1'b1, exp_v, 5, 0, 1'b0, "post_rst");
      m_ret[1] = exp_v;

      @(negedge clock);
      i_a = $urandom; i_b = $urandom; i_c = {$urandom, $urandom};
      i_acc = 1'($urandom_range(0, 1));
      exp_v = model(m_ret[0], i_acc, i_a, i_b, i_c);
      req1 = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge clock);
         cur_exp  = exp_v;
         m_ret[0] = cur_exp;
         if (j == 4) begin
            req1 = 1'b0;
         end else begin
            i_a = $urandom; i_b = $urandom; i_c = {$urandom, $urandom};
            i_acc = 1'($urandom_range(0, 1));
            exp_v = model(m_ret[0], i_acc, i_a, i_b, i_c);
         end
         @(negedge clock);
         chk($sformatf("b2b%0d_done_lo", j), 32'(done1), 32'd0);
         chk($sformatf("b2b%0d_busy", j), 32'(busy1), 32'd1);
         @(negedge clock);
         chk($sformatf("b2b%0d_done_hi", j), 32'(done1), 32'd1);
         chk($sformatf("b2b%0d_ret", j), ret1, cur_exp);
      end
      @(negedge clock);
      chk("b2b_end_idle", 32'(busy1), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
